// File: rtl/register4_sync_reset_pkg.sv
// Shared constants for the register4_sync_reset slice.
// The register itself is configured only through its own parameters.
package register4_sync_reset_pkg;

    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/register4_sync_reset.sv
// WIDTH-bit register, positive-edge clocked, with a synchronous active-high reset.
// q reloads on every rising edge; reset wins over the data load.
module register4_sync_reset
    import register4_sync_reset_pkg::*;
#(
    parameter int               WIDTH       = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;

    always_comb begin
        q_d = data;
        if (reset) begin
            q_d = RESET_VALUE;
        end
    end

    always_ff @(posedge clk) begin
        q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: tb/tb_register4_sync_reset.sv
// Bench for register4_sync_reset: every-edge model compare plus directed literal checks.
module tb_register4_sync_reset;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         clk_run = 1'b1;
    logic         reset;
    logic [W-1:0] data;
    logic [W-1:0] q;

    int n_cmp = 0;
    int n_bad = 0;

    register4_sync_reset #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .data  (data),
        .q     (q)
    );

    // Clock can be frozen at either level to exercise between-edge behaviour.
    initial forever begin
        #5;
        if (clk_run) clk = ~clk;
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: after each rising edge q equals RESET_VALUE if reset was high, else the sampled data.
    initial forever begin
        logic         r;
        logic [W-1:0] d;
        @(posedge clk);
        r = reset;
        d = data;
        #2;
        check("model", q, r ? 4'b0000 : d);
    end

    task automatic drive(input logic r, input logic [W-1:0] d);
        @(negedge clk);
        reset = r;
        data  = d;
    endtask

    task automatic after_edge;
        @(posedge clk);
        #3;
    endtask

    initial begin
        logic [W-1:0] exp_seq [4];
        logic [W-1:0] prev;
        exp_seq[0] = 4'b0001;
        exp_seq[1] = 4'b0011;
        exp_seq[2] = 4'b0111;
        exp_seq[3] = 4'b1111;

        reset = 1'b1;
        data  = 4'b1001;
        after_edge();
        check("reset_state", q, 4'b0000);

        // Load sequence, each value visible exactly one edge after presentation.
        for (int i = 0; i < 4; i++) begin
            prev = q;
            drive(1'b0, W'((1 << (i + 1)) - 1));
            #1 check("load_latency", q, prev);
            after_edge();
            check("load_seq", q, exp_seq[i]);
        end

        // Data toggling while clk is low must not disturb q.
        @(negedge clk);
        data = 4'b0000;
        #1 check("hold_low_a", q, 4'b1111);
        data = 4'b1111;
        #1 check("hold_low_b", q, 4'b1111);
        data = 4'b0000;
        #1 check("hold_low_c", q, 4'b1111);
        after_edge();
        check("hold_then_load", q, 4'b0000);
        drive(1'b0, 4'b1111);
        after_edge();
        check("reload_ones", q, 4'b1111);

        // Reset pulse with clk frozen high.
        @(posedge clk);
        #1 clk_run = 1'b0;
        reset = 1'b1;
        data  = 4'b0110;
        #3 reset = 1'b0;
        data = 4'b1111;
        #3 check("reset_no_edge_high", q, 4'b1111);
        clk_run = 1'b1;

        // Reset pulse with clk frozen low.
        @(negedge clk);
        #1 clk_run = 1'b0;
        reset = 1'b1;
        data  = 4'b0010;
        #3 reset = 1'b0;
        data = 4'b1111;
        #3 check("reset_no_edge_low", q, 4'b1111);
        clk_run = 1'b1;
        after_edge();
        check("after_freeze", q, 4'b1111);

        // Synchronous reset has priority over the data present at the same edge.
        drive(1'b1, 4'b1010);
        #1 check("reset_not_early", q, 4'b1111);
        after_edge();
        check("sync_reset", q, 4'b0000);

        // Release: data loads at the next edge, not before.
        drive(1'b0, 4'b0101);
        #1 check("release_before_edge", q, 4'b0000);
        after_edge();
        check("release_load", q, 4'b0101);

        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 7) == 0), W'($urandom));
        end
        @(posedge clk);
        #4;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        n_bad++;
        $display("FAIL timeout: bench did not complete, expected finish before %0t", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1);
    end

endmodule
